// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix engine: op codes, error codes, FSM states
// and the matrix-product accumulator width.
package matrix_pkg;

    typedef enum logic [2:0] {
        OP_TRANS = 3'd0,
        OP_ADD   = 3'd1,
        OP_SUB   = 3'd2,
        OP_SCALE = 3'd3,
        OP_HAD   = 3'd4,
        OP_MMUL  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_e;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_OP    = 2'd1;
    localparam logic [1:0] ERR_DIM   = 2'd2;
    localparam logic [1:0] ERR_SHAPE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_CALC   = 2'd2,
        S_OUTPUT = 2'd3
    } state_e;

    // Product of two DATA_W values summed up to 7 times needs 3 guard bits.
    function automatic int acc_width(input int data_w);
        return 2 * data_w + 3;
    endfunction

endpackage

// File: rtl/matrix_mac.sv
// Element datapath: full-precision element arithmetic, product accumulator and
// reduction to RES_W. Saturating reduction when MATRIX_SAT_EN is defined.
module matrix_mac
    import matrix_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RES_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_scalar,
    input  logic              i_mac_en,
    input  logic              i_clr,
    output logic [RES_W-1:0]  o_res
);

    localparam int ACC_W = acc_width(DATA_W);

    logic        [ACC_W-1:0]    r_acc;
    logic        [DATA_W-1:0]   w_mul_b;
    logic        [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W:0]      w_a_s;
    logic signed [ACC_W:0]      w_b_s;
    logic signed [ACC_W:0]      w_p_s;
    logic signed [ACC_W:0]      w_acc_s;
    logic signed [ACC_W:0]      w_full;

    function automatic logic [RES_W-1:0] reduce(input logic signed [ACC_W:0] v);
`ifdef MATRIX_SAT_EN
        if (v < 0)
            return '0;
        else if (v > $signed({{(ACC_W+1-RES_W){1'b0}}, {RES_W{1'b1}}}))
            return '1;
        else
            return RES_W'(v);
`else
        return RES_W'(v);
`endif
    endfunction

    assign w_mul_b = (i_op == OP_SCALE) ? i_scalar : i_b;
    assign w_prod  = (2*DATA_W)'(i_a) * (2*DATA_W)'(w_mul_b);
    assign w_a_s   = $signed({{(ACC_W+1-DATA_W){1'b0}}, i_a});
    assign w_b_s   = $signed({{(ACC_W+1-DATA_W){1'b0}}, i_b});
    assign w_p_s   = $signed({{(ACC_W+1-2*DATA_W){1'b0}}, w_prod});
    assign w_acc_s = $signed({1'b0, r_acc});

    always_comb begin
        w_full = '0;
        case (op_e'(i_op))
            OP_TRANS:        w_full = w_a_s;
            OP_ADD:          w_full = w_a_s + w_b_s;
            OP_SUB:          w_full = w_a_s - w_b_s;
            OP_SCALE,
            OP_HAD:          w_full = w_p_s;
            OP_MMUL:         w_full = w_acc_s;
            default:         w_full = '0;
        endcase
    end

    assign o_res = reduce(w_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else if (i_mac_en)
            r_acc <= r_acc + ACC_W'(w_prod);
    end

endmodule

// File: rtl/matrix_engine_p.sv
// Matrix engine top: request checking, IDLE/LOAD/CALC/OUTPUT sequencing and
// result array. Optional MATRIX_SAT_EN selects saturating result reduction.
module matrix_engine_p
    import matrix_pkg::*;
#(
    parameter int MAX_DIM = 5,
    parameter int DATA_W  = 8,
    parameter int RES_W   = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [2:0]                        op,
    input  logic [2:0]                        a_rows,
    input  logic [2:0]                        a_cols,
    input  logic [2:0]                        b_rows,
    input  logic [2:0]                        b_cols,
    input  logic [DATA_W-1:0]                 scalar,
    input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] a_data,
    input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] b_data,
    output logic [MAX_DIM*MAX_DIM*RES_W-1:0]  res_data,
    output logic [2:0]                        res_rows,
    output logic [2:0]                        res_cols,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [1:0]                        err_code
);

    localparam int N     = MAX_DIM * MAX_DIM;
    localparam int IDX_W = $clog2(N);

    state_e            r_state;
    logic [2:0]        r_op, r_arows, r_acols, r_bcols, r_rrows, r_rcols;
    logic [2:0]        r_i, r_j, r_k;
    logic [DATA_W-1:0] r_scalar;
    logic [DATA_W-1:0] r_a [N];
    logic [DATA_W-1:0] r_b [N];
    logic [RES_W-1:0]  r_res [N];

    logic [1:0]        w_err;
    logic              w_use_b, w_shape_eq, w_mmul, w_last_k, w_last_el;
    logic              w_mac_en, w_clr;
    logic [2:0]        w_kk;
    logic [IDX_W-1:0]  w_a_idx, w_b_idx, w_res_idx;
    logic [RES_W-1:0]  w_mac_res;

    function automatic logic dim_bad(input logic [2:0] d);
        return (d == 3'd0) || (d > 3'(MAX_DIM));
    endfunction

    always_comb begin
        w_err      = ERR_NONE;
        w_use_b    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_HAD) || (op == OP_MMUL);
        w_shape_eq = (op == OP_MMUL) ? (a_cols == b_rows)
                                     : (a_rows == b_rows) && (a_cols == b_cols);
        if (op > OP_MMUL)
            w_err = ERR_OP;
        else if (dim_bad(a_rows) || dim_bad(a_cols) ||
                 (w_use_b && (dim_bad(b_rows) || dim_bad(b_cols))))
            w_err = ERR_DIM;
        else if (w_use_b && !w_shape_eq)
            w_err = ERR_SHAPE;
    end

    // Product walks k over a_cols MAC cycles, then spends k == a_cols on the write.
    assign w_mmul    = (r_op == OP_MMUL);
    assign w_last_k  = (r_k == r_acols);
    assign w_kk      = w_last_k ? 3'd0 : r_k;
    assign w_last_el = (r_i == r_rrows - 3'd1) && (r_j == r_rcols - 3'd1);
    assign w_mac_en  = (r_state == S_CALC) && w_mmul && !w_last_k;
    assign w_clr     = (r_state == S_LOAD) || ((r_state == S_CALC) && w_mmul && w_last_k);
    assign w_res_idx = IDX_W'(r_i) * IDX_W'(r_rcols) + IDX_W'(r_j);

    always_comb begin
        w_a_idx = IDX_W'(r_i) * IDX_W'(r_acols) + IDX_W'(r_j);
        w_b_idx = w_a_idx;
        if (r_op == OP_TRANS) begin
            w_a_idx = IDX_W'(r_j) * IDX_W'(r_acols) + IDX_W'(r_i);
        end else if (w_mmul) begin
            w_a_idx = IDX_W'(r_i) * IDX_W'(r_acols) + IDX_W'(w_kk);
            w_b_idx = IDX_W'(w_kk) * IDX_W'(r_bcols) + IDX_W'(r_j);
        end
    end

    matrix_mac #(
        .DATA_W (DATA_W),
        .RES_W  (RES_W)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_op     (r_op),
        .i_a      (r_a[w_a_idx]),
        .i_b      (r_b[w_b_idx]),
        .i_scalar (r_scalar),
        .i_mac_en (w_mac_en),
        .i_clr    (w_clr),
        .o_res    (w_mac_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            {r_op, r_arows, r_acols, r_bcols, r_rrows, r_rcols} <= '0;
            {r_i, r_j, r_k} <= '0;
            r_scalar <= '0;
            for (int n = 0; n < N; n++) begin
                r_a[n]   <= '0;
                r_b[n]   <= '0;
                r_res[n] <= '0;
            end
            res_data <= '0;
            res_rows <= '0;
            res_cols <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && (w_err != ERR_NONE)) begin
                        error    <= 1'b1;
                        err_code <= w_err;
                    end else if (start) begin
                        // Latch with the accepted request so the stored shape is the checked one.
                        err_code <= ERR_NONE;
                        busy     <= 1'b1;
                        r_state  <= S_LOAD;
                        r_op     <= op;
                        r_arows  <= a_rows;
                        r_acols  <= a_cols;
                        r_bcols  <= b_cols;
                        r_scalar <= scalar;
                        for (int n = 0; n < N; n++) begin
                            r_a[n] <= a_data[n*DATA_W +: DATA_W];
                            r_b[n] <= b_data[n*DATA_W +: DATA_W];
                        end
                    end
                end
                S_LOAD: begin
                    {r_i, r_j, r_k} <= '0;
                    for (int n = 0; n < N; n++)
                        r_res[n] <= '0;
                    r_rrows <= (r_op == OP_TRANS) ? r_acols : r_arows;
                    r_rcols <= (r_op == OP_TRANS) ? r_arows :
                               (r_op == OP_MMUL)  ? r_bcols : r_acols;
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    if (w_mac_en) begin
                        r_k <= r_k + 3'd1;
                    end else begin
                        r_res[w_res_idx] <= w_mac_res;
                        r_k <= 3'd0;
                        if (w_last_el) begin
                            r_state <= S_OUTPUT;
                        end else if (r_j == r_rcols - 3'd1) begin
                            r_j <= 3'd0;
                            r_i <= r_i + 3'd1;
                        end else begin
                            r_j <= r_j + 3'd1;
                        end
                    end
                end
                S_OUTPUT: begin
                    for (int n = 0; n < N; n++)
                        res_data[n*RES_W +: RES_W] <= r_res[n];
                    res_rows <= r_rrows;
                    res_cols <= r_rcols;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_engine_p.sv
// Directed self-checking bench for matrix_engine_p (default or MATRIX_SAT_EN build).
module tb_matrix_engine_p;

    localparam int MAX_DIM = 5;
    localparam int DATA_W  = 8;
    localparam int RES_W   = 16;
    localparam int N       = MAX_DIM * MAX_DIM;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [2:0]            op = '0, a_rows = '0, a_cols = '0, b_rows = '0, b_cols = '0;
    logic [DATA_W-1:0]     scalar = '0;
    logic [N*DATA_W-1:0]   a_data = '0, b_data = '0;
    logic [N*RES_W-1:0]    res_data;
    logic [2:0]            res_rows, res_cols;
    logic                  busy, done, error;
    logic [1:0]            err_code;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    matrix_engine_p #(.MAX_DIM(MAX_DIM), .DATA_W(DATA_W), .RES_W(RES_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
        .scalar(scalar), .a_data(a_data), .b_data(b_data),
        .res_data(res_data), .res_rows(res_rows), .res_cols(res_cols),
        .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    task automatic pack(output logic [N*DATA_W-1:0] d, input int first, input int cnt);
        d = '0;
        for (int i = 0; i < cnt; i++) d[i*DATA_W +: DATA_W] = DATA_W'(first + i);
    endtask

    // Pulse start for one edge and wait (bounded) for done; lat counts edges from acceptance.
    task automatic run_op(output int lat, output bit saw_err);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        saw_err = error;
        while (!done && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (error) saw_err = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (res_data !== '0) begin n_fail++; $display("FAIL reset_res_data: got %0h expected 0", res_data); end
        n_checks++; if ({res_rows, res_cols} !== 6'd0) begin n_fail++; $display("FAIL reset_dims: got %0d/%0d expected 0/0", res_rows, res_cols); end
        n_checks++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, error}); end
        n_checks++; if (err_code !== 2'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d expected 0", err_code); end
        rst_n = 1'b1;
    endtask

    task automatic test_mmul(input string tag);
        int lat; bit se;
        int exp_v[4] = '{58, 64, 139, 154};
        op = 3'd5; a_rows = 3'd2; a_cols = 3'd3; b_rows = 3'd3; b_cols = 3'd2;
        pack(a_data, 1, 6); pack(b_data, 7, 6);
        run_op(lat, se);
        n_checks++; if (lat !== 19) begin n_fail++; $display("FAIL %s_latency: got %0d expected 19", tag, lat); end
        n_checks++; if (se) begin n_fail++; $display("FAIL %s_no_error: got 1 expected 0", tag); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (res_data[i*RES_W +: RES_W] !== RES_W'(exp_v[i])) begin
                n_fail++; $display("FAIL %s_elem%0d: got %0d expected %0d", tag, i, res_data[i*RES_W +: RES_W], exp_v[i]);
            end
        end
        n_checks++; if ({res_rows, res_cols} !== {3'd2, 3'd2}) begin n_fail++; $display("FAIL %s_dims: got %0d/%0d expected 2/2", tag, res_rows, res_cols); end
        n_checks++; if (res_data[N*RES_W-1:4*RES_W] !== '0) begin n_fail++; $display("FAIL %s_unused_zero: got %0h expected 0", tag, res_data[N*RES_W-1:4*RES_W]); end
        @(posedge clk); #1;
        n_checks++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL %s_done_pulse: got done,busy=%b expected 00", tag, {done, busy}); end
    endtask

    task automatic test_transpose();
        int lat; bit se;
        int exp_v[6] = '{1, 4, 2, 5, 3, 6};
        op = 3'd0; a_rows = 3'd2; a_cols = 3'd3; b_rows = 3'd0; b_cols = 3'd0;
        pack(a_data, 1, 6); b_data = '0;
        run_op(lat, se);
        n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL trans_latency: got %0d expected 9", lat); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (res_data[i*RES_W +: RES_W] !== RES_W'(exp_v[i])) begin
                n_fail++; $display("FAIL trans_elem%0d: got %0d expected %0d", i, res_data[i*RES_W +: RES_W], exp_v[i]);
            end
        end
        n_checks++; if ({res_rows, res_cols} !== {3'd3, 3'd2}) begin n_fail++; $display("FAIL trans_dims: got %0d/%0d expected 3/2", res_rows, res_cols); end
    endtask

    task automatic test_sub();
        int lat; bit se;
        logic [RES_W-1:0] exp_v;
`ifdef MATRIX_SAT_EN
        exp_v = 16'h0000;
`else
        exp_v = 16'hFFFE;
`endif
        op = 3'd2; a_rows = 3'd1; a_cols = 3'd1; b_rows = 3'd1; b_cols = 3'd1;
        a_data = '0; b_data = '0; a_data[7:0] = 8'd3; b_data[7:0] = 8'd5;
        run_op(lat, se);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL sub_latency: got %0d expected 4", lat); end
        n_checks++; if (res_data[RES_W-1:0] !== exp_v) begin n_fail++; $display("FAIL sub_value: got %0h expected %0h", res_data[RES_W-1:0], exp_v); end
        n_checks++; if ({res_rows, res_cols} !== {3'd1, 3'd1}) begin n_fail++; $display("FAIL sub_dims: got %0d/%0d expected 1/1", res_rows, res_cols); end
        n_checks++; if (res_data[N*RES_W-1:RES_W] !== '0) begin n_fail++; $display("FAIL sub_unused_zero: got %0h expected 0", res_data[N*RES_W-1:RES_W]); end
    endtask

    task automatic test_errors();
        int t_op[5]  = '{1, 6, 0, 5, 5};
        int t_ar[5]  = '{2, 1, 0, 2, 2};
        int t_ac[5]  = '{2, 1, 3, 3, 3};
        int t_br[5]  = '{2, 1, 1, 6, 2};
        int t_bc[5]  = '{3, 1, 1, 2, 2};
        int t_exp[5] = '{3, 1, 2, 2, 3};
        logic [RES_W-1:0] held;
        held = res_data[RES_W-1:0];
        for (int t = 0; t < 5; t++) begin
            op = 3'(t_op[t]); a_rows = 3'(t_ar[t]); a_cols = 3'(t_ac[t]);
            b_rows = 3'(t_br[t]); b_cols = 3'(t_bc[t]);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL err%0d_pulse: got %b expected 1", t, error); end
            n_checks++; if (err_code !== 2'(t_exp[t])) begin n_fail++; $display("FAIL err%0d_code: got %0d expected %0d", t, err_code, t_exp[t]); end
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                n_checks++;
                if ({error, busy, done} !== 3'b000 || err_code !== 2'(t_exp[t])) begin
                    n_fail++; $display("FAIL err%0d_after%0d: got err,busy,done=%b code=%0d expected 000 code=%0d", t, c, {error, busy, done}, err_code, t_exp[t]);
                end
            end
        end
        n_checks++; if (res_data[RES_W-1:0] !== held) begin n_fail++; $display("FAIL err_res_hold: got %0h expected %0h", res_data[RES_W-1:0], held); end
    endtask

    task automatic test_scale_busy();
        int lat; bit se;
        op = 3'd3; a_rows = 3'd5; a_cols = 3'd5; b_rows = 3'd0; b_cols = 3'd0;
        scalar = 8'd255; a_data = '1; b_data = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        se = error;
        n_checks++; if ({busy, err_code} !== {1'b1, 2'd0}) begin n_fail++; $display("FAIL scale_accept: got busy=%b code=%0d expected busy=1 code=0", busy, err_code); end
        while (!done && lat < 300) begin
            if (lat == 5) begin start = 1'b1; op = 3'd6; scalar = 8'd1; a_data = '0; end
            if (lat == 8) start = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (error) se = 1'b1;
        end
        start = 1'b0;
        n_checks++; if (lat !== 28) begin n_fail++; $display("FAIL scale_latency: got %0d expected 28", lat); end
        n_checks++; if (se) begin n_fail++; $display("FAIL scale_busy_start_error: got 1 expected 0"); end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (res_data[i*RES_W +: RES_W] !== 16'd65025) begin
                n_fail++; $display("FAIL scale_elem%0d: got %0d expected 65025", i, res_data[i*RES_W +: RES_W]);
            end
        end
        n_checks++; if ({res_rows, res_cols} !== {3'd5, 3'd5}) begin n_fail++; $display("FAIL scale_dims: got %0d/%0d expected 5/5", res_rows, res_cols); end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL scale_no_restart: got busy=%b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int lat; bit se;
        op = 3'd1; a_rows = 3'd1; a_cols = 3'd1; b_rows = 3'd1; b_cols = 3'd1;
        a_data = '0; b_data = '0; a_data[7:0] = 8'd200; b_data[7:0] = 8'd100;
        run_op(lat, se);
        n_checks++; if (res_data[RES_W-1:0] !== 16'd300) begin n_fail++; $display("FAIL b2b_add: got %0d expected 300", res_data[RES_W-1:0]); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_first: got %b expected 1", done); end
        op = 3'd4; a_rows = 3'd1; a_cols = 3'd2; b_rows = 3'd1; b_cols = 3'd2;
        pack(a_data, 2, 2); pack(b_data, 4, 2);
        run_op(lat, se);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 5", lat); end
        n_checks++; if (res_data[2*RES_W-1:0] !== {16'd15, 16'd8}) begin n_fail++; $display("FAIL b2b_hadamard: got %0h expected 000f0008", res_data[2*RES_W-1:0]); end
        n_checks++; if ({res_rows, res_cols} !== {3'd1, 3'd2}) begin n_fail++; $display("FAIL b2b_dims: got %0d/%0d expected 1/2", res_rows, res_cols); end
    endtask

    task automatic test_reset_mid_calc();
        bit saw_done = 1'b0;
        op = 3'd5; a_rows = 3'd2; a_cols = 3'd3; b_rows = 3'd3; b_cols = 3'd2;
        pack(a_data, 1, 6); pack(b_data, 7, 6);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (res_data !== '0 || {res_rows, res_cols} !== 6'd0) begin n_fail++; $display("FAIL rst_mid_result: got %0h %0d/%0d expected 0", res_data, res_rows, res_cols); end
        n_checks++; if ({busy, done, error, err_code} !== 5'd0) begin n_fail++; $display("FAIL rst_mid_flags: got %b expected 00000", {busy, done, error, err_code}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        n_checks++; if (saw_done) begin n_fail++; $display("FAIL rst_mid_no_done: got activity expected none"); end
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        test_mmul("post_rst_mmul");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mmul("mmul");
        test_transpose();
        test_sub();
        test_errors();
        test_scale_busy();
        test_back_to_back();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_engine_p.md
MATRIX_ENGINE_P -- requirements
Module: matrix_engine_p

Interface
REQ-001 Parameters SHALL be: MAX_DIM, 5, maximum rows/cols per operand (2..7); DATA_W, 8, operand element width, unsigned; RES_W, 16, result element width.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  3  operation code (matrix_pkg).
REQ-006 a_rows, a_cols, b_rows, b_cols  input  3 each  operand dimensions.
REQ-007 scalar  input  DATA_W  scale factor for OP_SCALE.
REQ-008 a_data, b_data  input  MAX_DIM*MAX_DIM*DATA_W  row-major operands, element i at [i*DATA_W +: DATA_W].
REQ-009 res_data  output  MAX_DIM*MAX_DIM*RES_W  row-major result, element i at [i*RES_W +: RES_W]; unused elements zero.
REQ-010 res_rows, res_cols  output  3 each  result dimensions.
REQ-011 busy  output  1  high in every non-IDLE state.
REQ-012 done  output  1  one-cycle pulse, result valid.
REQ-013 error  output  1  one-cycle pulse, request rejected.
REQ-014 err_code  output  2  reason, valid with error, held until next start accepted.

Function
REQ-015 Ops SHALL be: 0 transpose A, 1 A+B, 2 A-B, 3 A*scalar, 4 A.*B (Hadamard), 5 A x B (matrix product); 6-7 reserved.
REQ-016 FSM SHALL be IDLE -> LOAD -> CALC -> OUTPUT -> IDLE; LOAD and OUTPUT take exactly one cycle each.
REQ-017 In IDLE with start=1, checks SHALL run same cycle: reserved op -> err_code 1; any used dimension 0 or >MAX_DIM -> 2; shape mismatch (ops 1,2,4: A dims != B dims; op 5: a_cols != b_rows) -> 3; on failure error pulses next cycle, FSM stays IDLE.
REQ-018 LOAD SHALL register all operands, op, scalar, dimensions; inputs are ignored afterwards until IDLE.
REQ-019 CALC SHALL produce one element per cycle for ops 0-4 (rows*cols cycles) and, for op 5, a_cols MAC cycles plus one write cycle per element (a_rows*b_cols*(a_cols+1) cycles).
REQ-020 Element arithmetic SHALL be computed at full precision then reduced to RES_W per REQ-029/030; matrix-product accumulator SHALL be 2*DATA_W+3 bits and cleared per element.
REQ-021 OUTPUT SHALL copy the internal result array to res_data, set res_rows/res_cols (transpose: a_cols,a_rows; product: a_rows,b_cols; else A dims), zero unused elements; done pulses in the following IDLE cycle.
REQ-022 res_data/res_rows/res_cols SHALL hold until the next OUTPUT.
REQ-023 start during busy SHALL be ignored with no error; start in the cycle done is high SHALL be accepted.
REQ-024 Minimum total latency start-to-done for a 1x1 op 0-4 SHALL be 4 cycles.

Reset
REQ-025 rst_n low SHALL force IDLE immediately, abort any operation, and zero busy, done, error, err_code, res_data, res_rows, res_cols, all internal arrays and counters.
REQ-026 Reset mid-CALC SHALL produce no done pulse and no partial result.
REQ-027 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro MATRIX_SAT_EN SHALL select result reduction.
REQ-029 Defined: results above 2^RES_W-1 clamp to 2^RES_W-1; negative subtraction results clamp to 0.
REQ-030 Undefined: results take low RES_W bits (modulo 2^RES_W), subtraction wraps two's complement.

Structure
REQ-031 Package matrix_pkg SHALL hold op codes, err_code values, FSM state encoding, and accumulator-width function.
REQ-032 Sub-module matrix_mac SHALL implement the multiply-accumulate/clear/reduce datapath, instantiated once.
REQ-033 Implementation SHALL be 120-400 RTL lines, synthesizable, no latches.

Verification
REQ-034 Op 5, A=2x3 [1..6], B=3x2 [7..12] -> res [58,64,139,154], 2x2, done after 2*2*4+3 cycles.
REQ-035 Op 0, A=2x3 [1..6] -> res [1,4,2,5,3,6], res_rows 3, res_cols 2.
REQ-036 Op 2, A=[3], B=[5] 1x1 -> 0 with MATRIX_SAT_EN, 0xFFFE without.
REQ-037 Op 1, A 2x2, B 2x3 -> error pulse, err_code 3, no done, busy never high; op 6 -> err_code 1.
REQ-038 Op 3, 5x5 all 255, scalar 255 -> every element 65025; start reasserted during busy ignored.
REQ-039 rst_n pulsed low mid-CALC of op 5 -> all outputs zero, no done; next start completes correctly.
